// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - three-way round-robin arbiter for a single-port RAM with tagged read return (optional LOCK_EN)
module ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    input  logic              r2_req,
    input  logic              r2_we,
    input  logic [ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0] r2_wdata,
    input  logic              r2_lock,
    output logic              r2_gnt,
    output logic              r2_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          last;
    logic [2:0]          req_v;
    logic [2:0]          we_v;
    logic [2:0]          lock_v;
    logic [2:0]          elig;
    logic [2:0]          req_e;
    logic [1:0]          c0, c1, c2;
    logic [1:0]          win;
    logic                win_ok;
    logic                issue;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [2:0]          gnt_q;
    logic [2:0]          rvalid_q;
    logic [RAM_LAT-1:0]  tag_v;
    logic [1:0]          tag_id [RAM_LAT];

    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] rr_onehot(input logic [1:0] x);
        return 3'b001 << x;
    endfunction

    assign req_v  = {r2_req, r1_req, r0_req};
    assign we_v   = {r2_we, r1_we, r0_we};
    assign lock_v = {r2_lock, r1_lock, r0_lock};

`ifdef LOCK_EN
    // While locked only the locker (always the last winner) may be granted.
    assign elig = (state == LOCKED) ? rr_onehot(last) : 3'b111;
`else
    logic unused_lock;
    assign elig        = 3'b111;
    assign unused_lock = ^{lock_v, state};
`endif

    assign req_e = req_v & elig;

    // Round-robin search starting just after the last winner.
    always_comb begin
        c0     = rr_next(last);
        c1     = rr_next(c0);
        c2     = rr_next(c1);
        win    = c0;
        win_ok = 1'b0;
        if (req_e[c0]) begin
            win    = c0;
            win_ok = 1'b1;
        end else if (req_e[c1]) begin
            win    = c1;
            win_ok = 1'b1;
        end else if (req_e[c2]) begin
            win    = c2;
            win_ok = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: a lock survives cycles where the locker stops requesting.
    always_comb begin
        state_nx = IDLE;
        if (win_ok) begin
            state_nx = ISSUE;
`ifdef LOCK_EN
            if (lock_v[win]) begin
                state_nx = LOCKED;
            end
`endif
        end
`ifdef LOCK_EN
        else if (state == LOCKED) begin
            state_nx = LOCKED;
        end
`endif
    end

    // FSM outputs: the command selected for issue on the coming edge.
    always_comb begin
        issue     = win_ok;
        sel_we    = 1'b0;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        case (win)
            2'd1: begin
                sel_we    = we_v[1];
                sel_addr  = r1_addr;
                sel_wdata = r1_wdata;
            end
            2'd2: begin
                sel_we    = we_v[2];
                sel_addr  = r2_addr;
                sel_wdata = r2_wdata;
            end
            default: begin
                sel_we    = we_v[0];
                sel_addr  = r0_addr;
                sel_wdata = r0_wdata;
            end
        endcase
    end

    // Registered RAM command and grant; address/data hold when idle.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            gnt_q     <= 3'b000;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            last      <= 2'd2;
        end else begin
            gnt_q  <= issue ? rr_onehot(win) : 3'b000;
            ram_en <= issue;
            ram_we <= issue & sel_we;
            if (issue) begin
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
                last      <= win;
            end
        end
    end

    // Read tags travel alongside the RAM access; the last stage launches rvalid.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            tag_v    <= '0;
            rvalid_q <= 3'b000;
            rdata    <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_id[i] <= 2'd0;
            end
        end else begin
            tag_v[0]  <= issue & ~sel_we;
            tag_id[0] <= win;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            rvalid_q <= tag_v[RAM_LAT-1] ? rr_onehot(tag_id[RAM_LAT-1]) : 3'b000;
            if (tag_v[RAM_LAT-1]) begin
                rdata <= ram_rdata;
            end
        end
    end

    assign r0_gnt    = gnt_q[0];
    assign r1_gnt    = gnt_q[1];
    assign r2_gnt    = gnt_q[2];
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign r2_rvalid = rvalid_q[2];
    assign busy      = |tag_v;

endmodule
